dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-ported data memory between NUM_REQ cores (one per core data port).
//  Round-robin arbitration, one transaction in flight at a time, registered response path.
//  Screens misaligned accesses before they reach memory.
//  Sits between each core's load/store stage and the data memory in the multicore top.
// PARAMETERS
//  NUM_REQ  2   number of requesting cores (2..4)
//  ADDR_W   32  byte address width
//  DATA_W   32  data word width (fixed 32 for RV32)
// PORTS
//  clk         in   1               system clock, all logic on posedge
//  reset       in   1               synchronous, active-low reset
//  req_valid   in   NUM_REQ         per-core request valid
//  req_ready   out  NUM_REQ         per-core accept; transfer when valid&ready
//  req_we      in   NUM_REQ         1=store, 0=load
//  req_addr    in   NUM_REQ*ADDR_W  byte address, core i in slice [i*ADDR_W +: ADDR_W]
//  req_wdata   in   NUM_REQ*DATA_W  store data
//  req_mask    in   NUM_REQ*3       funct3 size/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu)
//  resp_valid  out  NUM_REQ         one-cycle response pulse to the owning core
//  resp_rdata  out  DATA_W          load result (shared bus, qualified by resp_valid)
//  resp_err    out  1               misaligned/illegal access, qualified by resp_valid
//  mem_addr    out  ADDR_W          to data memory
//  mem_wdata   out  DATA_W          to data memory
//  mem_mask    out  3               to data memory
//  mem_wr_en   out  1               to data memory
//  mem_rd_en   out  1               to data memory
//  mem_rdata   in   DATA_W          from data memory (combinational read)
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, rr_ptr=0, all req_ready/resp_valid/resp_err=0,
//   resp_rdata=0, mem_* outputs=0. Reset mid-transaction aborts it: no write, no response.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: if any req_valid, pick winner = first valid at or after rr_ptr (wrapping);
//    req_ready[winner]=1 combinationally that cycle, only for the winner; capture
//    we/addr/wdata/mask/id into an internal register; go ACCESS. None valid: stay.
//   ACCESS: drive mem_* from captured registers for exactly one cycle
//    (mem_wr_en=we, mem_rd_en=~we); if captured access misaligned, keep
//    mem_wr_en=mem_rd_en=0 and set err flag. Register mem_rdata on load. Go RESP.
//   RESP: resp_valid[id]=1, resp_rdata=captured load data (0 for store/err), resp_err=flag;
//    rr_ptr <= (id+1) mod NUM_REQ; go IDLE.
//  Latency: accept at cycle N, memory access N+1, resp_valid N+2; throughput 1 txn / 3 cycles.
//  req_ready is 0 in ACCESS and RESP; mem_wr_en/mem_rd_en are 0 outside ACCESS.
//  Misaligned: mask 001/101 with addr[0]=1; mask 010 with addr[1:0]!=0; mask 011/110/111 illegal.
//  Simultaneous requests: rr_ptr decides; a waiting core is granted within NUM_REQ transactions.
//  Requester may change inputs after accept; arbiter uses only captured values.
//  rr_ptr advances only on completed transactions; wraps NUM_REQ-1 -> 0.
// STRUCTURE
//  Shared package dmem_pkg: typedef enum {IDLE,ACCESS,RESP} arb_state_t; mask constants
//   MASK_B/MASK_H/MASK_W/MASK_BU/MASK_HU; function is_misaligned(mask,addr[1:0]).
//  One sub-module: rr_picker (combinational: valid vector + ptr -> one-hot grant + index).
//  FSM, capture registers and response register stay in dmem_arbiter.
// TESTING
//  Single core0 sw addr=0x10 data=0xDEADBEEF, then lw 0x10 -> two responses, rdata=0xDEADBEEF, err=0.
//  Both cores valid same cycle from reset -> core0 granted first, core1 next; alternation
//   persists under continuous requests (rr_ptr 0,1,0,1).
//  Core1 lh addr=0x13 -> mem_wr_en/mem_rd_en stay 0, resp_valid[1]=1 with resp_err=1, rdata=0.
//  reset=0 during ACCESS of a store to 0x20 -> no resp_valid, later lw 0x20 returns old value.
//  sb 0x41 data=0xAB over word 0x11223344 at 0x40 then lbu 0x41 -> 0x000000AB; lb -> 0xFFFFFFAB.
//  Check every txn: resp_valid exactly 2 cycles after accept, only one req_ready high at a time.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, access-size codes and alignment screen for the data-memory arbiter
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  // Codes 011/110/111 have no defined size and are reported like a misalignment.
  function automatic logic is_misaligned(input logic [2:0] mask, input logic [1:0] addr_lo);
    case (mask)
      MASK_B, MASK_BU: return 1'b0;
      MASK_H, MASK_HU: return addr_lo[0];
      MASK_W:          return addr_lo != 2'b00;
      default:         return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin pick of the first valid requester at or after the pointer
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               hit
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!hit && valid[cand]) begin
        hit         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one data memory port among core load/store stages
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*3-1:0]      req_mask,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [2:0]                mem_mask,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   win_idx;
  logic               any_valid;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   cap_id;
  logic               cap_we;
  logic [ADDR_W-1:0]  cap_addr;
  logic [DATA_W-1:0]  cap_wdata;
  logic [2:0]         cap_mask;
  logic               cap_mis;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic               in_idle, in_access, in_resp;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .grant(grant),
    .idx  (win_idx),
    .hit  (any_valid)
  );

  assign cap_mis = is_misaligned(cap_mask, cap_addr[1:0]);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr    <= '0;
      cap_id    <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_mask  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_valid) begin
          cap_id    <= win_idx;
          cap_we    <= req_we[win_idx];
          cap_addr  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          cap_wdata <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
          cap_mask  <= req_mask[int'(win_idx)*3 +: 3];
        end
        ACCESS: begin
          err_q   <= cap_mis;
          rdata_q <= (!cap_we && !cap_mis) ? mem_rdata : '0;
        end
        RESP: rr_ptr <= (cap_id == IDX_W'(NUM_REQ-1)) ? '0 : cap_id + IDX_W'(1);
        default: ;
      endcase
    end
  end

  // Outputs are gated by reset so an abort during ACCESS never reaches memory.
  assign in_idle   = reset && (state_q == IDLE);
  assign in_access = reset && (state_q == ACCESS);
  assign in_resp   = reset && (state_q == RESP);

  assign req_ready  = in_idle ? grant : '0;

  assign mem_addr   = in_access ? cap_addr  : '0;
  assign mem_wdata  = in_access ? cap_wdata : '0;
  assign mem_mask   = in_access ? cap_mask  : '0;
  assign mem_wr_en  = in_access &  cap_we & ~cap_mis;
  assign mem_rd_en  = in_access & ~cap_we & ~cap_mis;

  assign resp_valid = in_resp ? (NUM_REQ'(1) << cap_id) : '0;
  assign resp_rdata = in_resp ? rdata_q : '0;
  assign resp_err   = in_resp & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with byte-array memory and reference model
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*3-1:0]  req_mask = '0;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [2:0]      mem_mask;
  logic            mem_wr_en;
  logic            mem_rd_en;
  logic [DW-1:0]   mem_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
  );

  // Data memory device: 256 bytes, little-endian, sign/zero extension done here.
  logic [7:0] dev_mem [256];
  bit         dev_init = 1'b0;
  logic [7:0] d0, d1, d2, d3;
  assign d0 = dev_mem[mem_addr[7:0]];
  assign d1 = dev_mem[8'(mem_addr[7:0] + 8'd1)];
  assign d2 = dev_mem[8'(mem_addr[7:0] + 8'd2)];
  assign d3 = dev_mem[8'(mem_addr[7:0] + 8'd3)];

  always_comb begin
    mem_rdata = '0;
    case (mem_mask)
      3'b000:  mem_rdata = {{24{d0[7]}}, d0};
      3'b100:  mem_rdata = {24'h0, d0};
      3'b001:  mem_rdata = {{16{d1[7]}}, d1, d0};
      3'b101:  mem_rdata = {16'h0, d1, d0};
      3'b010:  mem_rdata = {d3, d2, d1, d0};
      default: mem_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (!dev_init) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= 8'(i * 7 + 3);
      dev_init <= 1'b1;
    end else if (mem_wr_en) begin
      dev_mem[mem_addr[7:0]] <= mem_wdata[7:0];
      if (mem_mask[1:0] != 2'b00) dev_mem[8'(mem_addr[7:0] + 8'd1)] <= mem_wdata[15:8];
      if (mem_mask[1:0] == 2'b10) begin
        dev_mem[8'(mem_addr[7:0] + 8'd2)] <= mem_wdata[23:16];
        dev_mem[8'(mem_addr[7:0] + 8'd3)] <= mem_wdata[31:24];
      end
    end
  end

  // Reference model: what each accepted request must produce, from the request alone.
  logic [7:0] ref_mem [256];
  bit         ref_init = 1'b0;

  function automatic int access_size(input logic [2:0] m);
    case (m)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit model_bad(input logic [2:0] m, input logic [31:0] a);
    int sz;
    sz = access_size(m);
    if (sz == 0) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] m);
    logic [31:0] v;
    int sz;
    sz = access_size(m);
    v = 0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[8'(a + i)]) << (8 * i));
    if (m[2] == 1'b0 && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  int          cyc = 0;
  bit          inflight = 1'b0;
  int          acc_cyc = 0;
  int          in_id = 0;
  logic        in_we;
  logic [31:0] in_addr, in_wdata;
  logic [2:0]  in_mask;
  int          model_ptr = 0;
  int          grant_log [$];
  int          mem_en_cycles = 0;
  int          resp_pulses = 0;

  always @(negedge clk) begin
    bit was, bad;
    int winner;
    logic [N-1:0] exp_grant;
    logic [31:0] exp_rdata;
    cyc++;
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
      ref_init = 1'b1;
    end
    if (mem_wr_en || mem_rd_en) mem_en_cycles++;
    if (|resp_valid) resp_pulses++;
    n_cmp++;
    if ($countones(req_ready) > 1) begin
      n_fail++;
      $display("FAIL ready_onehot: req_ready=%b at cycle %0d, required at most one bit", req_ready, cyc);
    end
    if (!reset) begin
      inflight  = 1'b0;
      model_ptr = 0;
    end else begin
      was = inflight;
      bad = model_bad(in_mask, in_addr);
      if (was && cyc == acc_cyc + 1) begin
        n_cmp++;
        if (mem_wr_en !== (in_we && !bad) || mem_rd_en !== (!in_we && !bad)) begin
          n_fail++;
          $display("FAIL access_en: wr=%b rd=%b, required wr=%b rd=%b", mem_wr_en, mem_rd_en, in_we && !bad, !in_we && !bad);
        end
        if (!bad) begin
          n_cmp++;
          if (mem_addr !== in_addr || mem_mask !== in_mask || (in_we && mem_wdata !== in_wdata)) begin
            n_fail++;
            $display("FAIL access_bus: addr=%h mask=%b wdata=%h, required addr=%h mask=%b wdata=%h",
                     mem_addr, mem_mask, mem_wdata, in_addr, in_mask, in_wdata);
          end
        end
      end else begin
        n_cmp++;
        if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_mem_en: wr=%b rd=%b at cycle %0d, required 0 0", mem_wr_en, mem_rd_en, cyc);
        end
      end
      if (was && cyc == acc_cyc + 2) begin
        exp_rdata = (in_we || bad) ? 32'h0 : ref_load(in_addr, in_mask);
        n_cmp++;
        if (resp_valid !== N'(1 << in_id) || resp_err !== bad || resp_rdata !== exp_rdata) begin
          n_fail++;
          $display("FAIL response: valid=%b err=%b rdata=%h, required valid=%b err=%b rdata=%h",
                   resp_valid, resp_err, resp_rdata, N'(1 << in_id), bad, exp_rdata);
        end
        if (in_we && !bad)
          for (int i = 0; i < access_size(in_mask); i++) ref_mem[8'(in_addr + i)] = in_wdata[8*i +: 8];
        model_ptr = (in_id + 1) % N;
        inflight  = 1'b0;
      end else begin
        n_cmp++;
        if (resp_valid !== '0) begin
          n_fail++;
          $display("FAIL stray_resp: resp_valid=%b at cycle %0d, required 0", resp_valid, cyc);
        end
      end
      if (was) begin
        n_cmp++;
        if (req_ready !== '0) begin
          n_fail++;
          $display("FAIL busy_ready: req_ready=%b while busy, required 0", req_ready);
        end
      end else begin
        winner = -1;
        for (int k = 0; k < N; k++)
          if (winner < 0 && req_valid[(model_ptr + k) % N]) winner = (model_ptr + k) % N;
        exp_grant = '0;
        if (winner >= 0) exp_grant[winner] = 1'b1;
        n_cmp++;
        if (req_ready !== exp_grant) begin
          n_fail++;
          $display("FAIL grant: req_ready=%b, required %b (valid=%b ptr=%0d)", req_ready, exp_grant, req_valid, model_ptr);
        end
        if (winner >= 0) begin
          inflight = 1'b1;
          acc_cyc  = cyc;
          in_id    = winner;
          in_we    = req_we[winner];
          in_addr  = req_addr[winner*AW +: AW];
          in_wdata = req_wdata[winner*DW +: DW];
          in_mask  = req_mask[winner*3 +: 3];
          grant_log.push_back(winner);
        end
      end
    end
  end

  task automatic do_txn(input int c, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] mask, output logic [31:0] rdata, output logic err, output bit ok);
    bit acc;
    ok = 1'b0; acc = 1'b0; rdata = '0; err = 1'b0;
    @(posedge clk); #1;
    req_we[c] = we;
    req_addr[c*AW +: AW] = addr;
    req_wdata[c*DW +: DW] = wdata;
    req_mask[c*3 +: 3] = mask;
    req_valid[c] = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (req_ready[c]) acc = 1'b1;
    end
    @(posedge clk); #1;
    req_valid[c] = 1'b0;
    req_addr[c*AW +: AW] = $urandom;
    req_wdata[c*DW +: DW] = $urandom;
    if (!acc) return;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (resp_valid[c]) begin
        rdata = resp_rdata;
        err = resp_err;
        ok = 1'b1;
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 2'b11;
    req_we = 2'b01;
    req_addr = {32'h14, 32'h10};
    req_mask = {MASK_W, MASK_W};
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_ready !== '0 || resp_valid !== '0 || resp_err !== 1'b0 || resp_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_resp: ready=%b valid=%b err=%b rdata=%h, required all 0", req_ready, resp_valid, resp_err, resp_rdata);
    end
    n_cmp++;
    if (mem_addr !== '0 || mem_wdata !== '0 || mem_mask !== '0 || mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mem: addr=%h wdata=%h mask=%b wr=%b rd=%b, required all 0", mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_rd_en);
    end
    req_valid = '0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; bit ok;
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, MASK_W, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b0 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL sw_resp: ok=%0d err=%b rdata=%h, required ok=1 err=0 rdata=0", ok, er, rd);
    end
    do_txn(0, 1'b0, 32'h10, 32'h0, MASK_W, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lw_resp: ok=%0d err=%b rdata=%h, required ok=1 err=0 rdata=deadbeef", ok, er, rd);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [6] = '{0, 1, 0, 1, 0, 1};
    bit ok0 = 1'b1, ok1 = 1'b1;
    apply_reset();
    grant_log.delete();
    fork
      begin
        logic [31:0] rd; logic er; bit ok;
        for (int i = 0; i < 3; i++) begin
          do_txn(0, 1'b0, 32'h10, 32'h0, MASK_W, rd, er, ok);
          ok0 = ok0 & ok;
        end
      end
      begin
        logic [31:0] rd; logic er; bit ok;
        for (int i = 0; i < 3; i++) begin
          do_txn(1, 1'b0, 32'h14, 32'h0, MASK_W, rd, er, ok);
          ok1 = ok1 & ok;
        end
      end
    join
    n_cmp++;
    if (!ok0 || !ok1 || grant_log.size() != 6) begin
      n_fail++;
      $display("FAIL rr_count: ok0=%0d ok1=%0d grants=%0d, required 1 1 6", ok0, ok1, grant_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (grant_log[i] != exp_seq[i]) begin
          n_fail++;
          $display("FAIL rr_order: grant %0d went to core %0d, required core %0d", i, grant_log[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; bit ok; int en0;
    en0 = mem_en_cycles;
    do_txn(1, 1'b0, 32'h13, 32'h0, MASK_H, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b1 || rd !== 32'h0 || mem_en_cycles != en0) begin
      n_fail++;
      $display("FAIL lh_misaligned: ok=%0d err=%b rdata=%h mem_en_cycles=%0d, required 1 1 0 0", ok, er, rd, mem_en_cycles - en0);
    end
    do_txn(0, 1'b1, 32'h10, 32'h5555_5555, 3'b011, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b1 || mem_en_cycles != en0) begin
      n_fail++;
      $display("FAIL illegal_mask: ok=%0d err=%b mem_en_cycles=%0d, required 1 1 0", ok, er, mem_en_cycles - en0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; bit ok, acc; int p0;
    do_txn(0, 1'b1, 32'h20, 32'hCAFEF00D, MASK_W, rd, er, ok);
    @(posedge clk); #1;
    req_we[0] = 1'b1;
    req_addr[0 +: AW] = 32'h20;
    req_wdata[0 +: DW] = 32'h1234_5678;
    req_mask[0 +: 3] = MASK_W;
    req_valid[0] = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      if (req_ready[0]) acc = 1'b1;
    end
    p0 = resp_pulses;
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (!acc || mem_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_write: accepted=%0d mem_wr_en=%b, required 1 0", acc, mem_wr_en);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (resp_pulses != p0) begin
      n_fail++;
      $display("FAIL abort_resp: %0d responses after abort, required 0", resp_pulses - p0);
    end
    do_txn(0, 1'b0, 32'h20, 32'h0, MASK_W, rd, er, ok);
    n_cmp++;
    if (!ok || rd !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL abort_old_value: ok=%0d rdata=%h, required 1 cafef00d", ok, rd);
    end
  endtask

  task automatic test_byte_ext();
    logic [31:0] rd; logic er; bit ok;
    do_txn(0, 1'b1, 32'h40, 32'h11223344, MASK_W, rd, er, ok);
    do_txn(0, 1'b1, 32'h41, 32'hFFFF_FFAB, MASK_B, rd, er, ok);
    do_txn(1, 1'b0, 32'h41, 32'h0, MASK_BU, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b0 || rd !== 32'h0000_00AB) begin
      n_fail++;
      $display("FAIL lbu: ok=%0d err=%b rdata=%h, required 1 0 000000ab", ok, er, rd);
    end
    do_txn(0, 1'b0, 32'h41, 32'h0, MASK_B, rd, er, ok);
    n_cmp++;
    if (!ok || er !== 1'b0 || rd !== 32'hFFFF_FFAB) begin
      n_fail++;
      $display("FAIL lb: ok=%0d err=%b rdata=%h, required 1 0 ffffffab", ok, er, rd);
    end
    do_txn(1, 1'b0, 32'h40, 32'h0, MASK_W, rd, er, ok);
    n_cmp++;
    if (!ok || rd !== 32'h1122_AB44) begin
      n_fail++;
      $display("FAIL sb_merge: ok=%0d rdata=%h, required 1 1122ab44", ok, rd);
    end
  endtask

  task automatic rand_txn(input int c);
    logic [2:0] masks [7] = '{MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU, 3'b011, 3'b110};
    logic [31:0] rd; logic er; bit ok;
    do_txn(c, 1'($urandom_range(0, 1)), 32'h80 + 32'($urandom_range(0, 63)), $urandom,
           masks[$urandom_range(0, 6)], rd, er, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rand_timeout: core %0d got no response, required one", c);
    end
  endtask

  task automatic test_random();
    int sel;
    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(1, 3);
      fork
        begin if (sel[0]) rand_txn(0); end
        begin if (sel[1]) rand_txn(1); end
      join
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_round_robin();
    test_misaligned();
    test_reset_mid();
    test_byte_ext();
    test_random();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
